// File: rtl/pole_result_arbiter.sv
// Merges the eight pole-search peak streams (max/min per channel) onto one valid/ready result bus.
// Each stream has a one-deep holding slot; slots drain round-robin and overwritten results are counted.
module pole_result_arbiter #(
    parameter int DW     = 16,
    parameter int OVR_CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                detect_enable,
    input  logic [4*DW-1:0]     max_dat,
    input  logic [3:0]          max_en,
    input  logic [4*DW-1:0]     min_dat,
    input  logic [3:0]          min_en,
    input  logic                clr_ovr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_dat,
    output logic [1:0]          out_ch,
    output logic                out_is_min,
    output logic [7:0]          ovr_flags,
    output logic [OVR_CW-1:0]   ovr_cnt
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      hold_q [8];
    logic [DW-1:0]      hold_d [8];
    logic [DW-1:0]      stb_dat [8];
    logic [7:0]         stb;
    logic [7:0]         pend_q, pend_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         grant, idx;
    logic               grant_vld;
    logic               pop;
    logic [7:0]         ovr_now;
    logic [3:0]         n_ovr;
    logic [7:0]         ovr_q, ovr_d;
    logic [OVR_CW-1:0]  cnt_q, cnt_d;
    logic [OVR_CW+3:0]  cnt_sum;
    logic [DW-1:0]      dat_q, dat_d;
    logic [1:0]         ch_q, ch_d;
    logic               is_min_q, is_min_d;

    // Slot i = max of channel i for i<4, min of channel i-4 otherwise.
    always_comb begin
        stb = {min_en, max_en} & {8{detect_enable}};
        for (int unsigned c = 0; c < 4; c++) begin
            stb_dat[c]   = max_dat[c*DW +: DW];
            stb_dat[c+4] = min_dat[c*DW +: DW];
        end
    end

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = rr_q + 3'(k);
            if (!grant_vld && pend_q[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = PRESENT;
            PRESENT: if (out_ready && !grant_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        pop      = grant_vld && (state_q == IDLE || out_ready);
        dat_d    = dat_q;
        ch_d     = ch_q;
        is_min_d = is_min_q;
        rr_d     = rr_q;
        if (pop) begin
            dat_d    = hold_q[grant];
            ch_d     = grant[1:0];
            is_min_d = grant[2];
            rr_d     = grant + 3'd1;
        end

        // A strobe on the slot being popped refills it without counting an overrun.
        n_ovr = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ovr_now[i] = stb[i] && pend_q[i] && !(pop && grant == 3'(i));
            pend_d[i]  = stb[i] || (pend_q[i] && !(pop && grant == 3'(i)));
            hold_d[i]  = stb[i] ? stb_dat[i] : hold_q[i];
            n_ovr      = n_ovr + 4'(ovr_now[i]);
        end

        cnt_sum = {4'b0, cnt_q} + (OVR_CW+4)'(n_ovr);
        if (clr_ovr) begin
            ovr_d = '0;
            cnt_d = '0;
        end else begin
            ovr_d = ovr_q | ovr_now;
            cnt_d = (|cnt_sum[OVR_CW+3:OVR_CW]) ? '1 : cnt_sum[OVR_CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q   <= '0;
            rr_q     <= '0;
            ovr_q    <= '0;
            cnt_q    <= '0;
            dat_q    <= '0;
            ch_q     <= '0;
            is_min_q <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) hold_q[i] <= '0;
        end else begin
            pend_q   <= pend_d;
            rr_q     <= rr_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            ch_q     <= ch_d;
            is_min_q <= is_min_d;
            for (int unsigned i = 0; i < 8; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign out_valid  = (state_q == PRESENT);
    assign out_dat    = dat_q;
    assign out_ch     = ch_q;
    assign out_is_min = is_min_q;
    assign ovr_flags  = ovr_q;
    assign ovr_cnt    = cnt_q;

endmodule

// File: tb/tb_pole_result_arbiter.sv
// Scoreboard bench for pole_result_arbiter: expected results are queued when strobes are driven
// and compared in order whenever the DUT completes a handshake.
module tb_pole_result_arbiter;

    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] dat;
        logic [1:0]    ch;
        logic          is_min;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            detect_enable;
    logic [4*DW-1:0] max_dat, min_dat;
    logic [3:0]      max_en, min_en;
    logic            clr_ovr;
    logic            out_valid, out_ready, out_is_min;
    logic [DW-1:0]   out_dat;
    logic [1:0]      out_ch;
    logic [7:0]      ovr_flags;
    logic [7:0]      ovr_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_unexp  = 0;

    pole_result_arbiter #(.DW(DW), .OVR_CW(8)) dut (
        .clk(clk), .rst(rst), .detect_enable(detect_enable),
        .max_dat(max_dat), .max_en(max_en), .min_dat(min_dat), .min_en(min_en),
        .clr_ovr(clr_ovr), .out_valid(out_valid), .out_ready(out_ready),
        .out_dat(out_dat), .out_ch(out_ch), .out_is_min(out_is_min),
        .ovr_flags(ovr_flags), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [DW-1:0] v);
        if (i < 4) begin
            max_en[i]           = 1'b1;
            max_dat[i*DW +: DW] = v;
        end else begin
            min_en[i-4]             = 1'b1;
            min_dat[(i-4)*DW +: DW] = v;
        end
    endtask

    task automatic clr_stb();
        max_en = '0;
        min_en = '0;
    endtask

    task automatic push_exp(input int slot, input logic [DW-1:0] v);
        exp_t e;
        logic [2:0] s;
        s        = 3'(slot);
        e.dat    = v;
        e.ch     = s[1:0];
        e.is_min = s[2];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        detect_enable = 1'b1;
        clr_ovr       = 1'b0;
        out_ready     = 1'b0;
        max_dat       = '0;
        min_dat       = '0;
        clr_stb();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Scoreboard consumer: compare every accepted result against the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_unexp++;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_dat", 32'(out_dat), 32'(e.dat));
                check("out_ch", 32'(out_ch), 32'(e.ch));
                check("out_is_min", 32'(out_is_min), 32'(e.is_min));
            end
        end
    end

    initial begin
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_dat", 32'(out_dat), 0);
        check("rst_flags", 32'(ovr_flags), 0);
        check("rst_cnt", 32'(ovr_cnt), 0);

        // Single max result on channel 2, link idle
        out_ready = 1'b1;
        set_slot(2, 16'h1234);
        push_exp(2, 16'h1234);
        tick();
        clr_stb();
        check("lat_t1", 32'(out_valid), 0);
        tick();
        check("lat_t2", 32'(out_valid), 1);
        tick();
        check("lat_t3", 32'(out_valid), 0);

        // All eight slots at once drain back-to-back in slot order
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_slot(i, 16'hA000 + 16'(i));
            push_exp(i, 16'hA000 + 16'(i));
        end
        tick();
        clr_stb();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("b2b_valid", 32'(out_valid), 1);
        end
        tick();
        check("b2b_end", 32'(out_valid), 0);
        check("b2b_drain", 32'(sb.size()), 0);

        // Stall the bus, then overrun slot 5
        do_reset();
        set_slot(0, 16'h0AAA);
        push_exp(0, 16'h0AAA);
        tick();
        clr_stb();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_dat", 32'(out_dat), 32'h0AAA);
            check("stall_ch", 32'(out_ch), 0);
            check("stall_min", 32'(out_is_min), 0);
        end
        set_slot(5, 16'h0010);
        tick();
        clr_stb();
        set_slot(5, 16'h0020);
        tick();
        clr_stb();
        check("ovr_flags1", 32'(ovr_flags), 32'h20);
        check("ovr_cnt1", 32'(ovr_cnt), 1);
        for (int k = 0; k < 300; k++) begin
            set_slot(5, 16'h0100 + 16'(k));
            tick();
        end
        clr_stb();
        check("ovr_sat", 32'(ovr_cnt), 32'hFF);
        set_slot(5, 16'h0777);
        clr_ovr = 1'b1;
        tick();
        clr_stb();
        clr_ovr = 1'b0;
        check("clr_wins_flags", 32'(ovr_flags), 0);
        check("clr_wins_cnt", 32'(ovr_cnt), 0);
        set_slot(5, 16'h0020);
        tick();
        clr_stb();
        check("ovr_flags2", 32'(ovr_flags), 32'h20);
        check("ovr_cnt2", 32'(ovr_cnt), 1);
        push_exp(5, 16'h0020);
        out_ready = 1'b1;
        tick();
        tick();
        check("ovr_idle", 32'(out_valid), 0);
        check("ovr_drain", 32'(sb.size()), 0);

        // detect_enable=0 drops strobes but pending slots still drain
        do_reset();
        set_slot(0, 16'h0BBB);
        push_exp(0, 16'h0BBB);
        tick();
        clr_stb();
        tick();
        set_slot(3, 16'h0333);
        push_exp(3, 16'h0333);
        tick();
        clr_stb();
        detect_enable = 1'b0;
        for (int i = 0; i < 8; i++) set_slot(i, 16'hDEAD);
        tick();
        clr_stb();
        check("den_cnt", 32'(ovr_cnt), 0);
        check("den_flags", 32'(ovr_flags), 0);
        out_ready = 1'b1;
        tick();
        tick();
        check("den_idle", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) set_slot(i, 16'hBEEF);
        tick();
        clr_stb();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("den_novalid", 32'(out_valid), 0);
        end
        check("den_drain", 32'(sb.size()), 0);
        detect_enable = 1'b1;

        // Reset mid-presentation discards the bus and all pending slots
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 16'h0600 + 16'(i));
        tick();
        clr_stb();
        tick();
        check("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_dat", 32'(out_dat), 0);
        check("mid_rst_ch", 32'(out_ch), 0);
        check("mid_rst_min", 32'(out_is_min), 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_valid", 32'(out_valid), 0);
        end

        check("unexpected_results", 32'(n_unexp), 0);
        check("sb_final", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
